// File: rtl/aes256_round_ctrl_if.sv
// aes256_round_ctrl_if
// Handshake and datapath-control bundle between the AES-256 round sequencer
// and its environment.
//   master : block source, key expansion and result consumer
//            (drives in_valid, key_ack, out_ready)
//   slave  : the round controller
//            (drives in_ready, key_req, round, sel_init, reg_wr_en, busy, out_valid)
// With AES_CTRL_ABORT_EN defined, the bundle also carries abort (master to
// slave) and aborted (slave to master).
interface aes256_round_ctrl_if #(
    parameter int RW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic          key_req;
    logic          key_ack;
    logic [RW-1:0] round;
    logic          sel_init;
    logic          reg_wr_en;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
`ifdef AES_CTRL_ABORT_EN
    logic          abort;
    logic          aborted;

    modport master (
        output in_valid, key_ack, out_ready, abort,
        input  in_ready, key_req, round, sel_init, reg_wr_en, busy, out_valid, aborted
    );
    modport slave (
        input  in_valid, key_ack, out_ready, abort,
        output in_ready, key_req, round, sel_init, reg_wr_en, busy, out_valid, aborted
    );
`else
    modport master (
        output in_valid, key_ack, out_ready,
        input  in_ready, key_req, round, sel_init, reg_wr_en, busy, out_valid
    );
    modport slave (
        input  in_valid, key_ack, out_ready,
        output in_ready, key_req, round, sel_init, reg_wr_en, busy, out_valid
    );
`endif
endinterface

// File: rtl/aes256_round_ctrl.sv
// aes256_round_ctrl
// Round sequencer for the AES-256 encryption datapath. After a block is
// accepted it walks rounds 0..NR. For each round it requests the round key,
// waits SETTLE cycles for the datapath, and then strobes the state register
// write enable. When the last round has been written it holds out_valid
// until the consumer takes the result.
// Ports:
//   clk     : clock
//   resetn  : asynchronous active-low reset
//   bus     : aes256_round_ctrl_if.slave, carrying the in/out handshakes,
//             the key request/ack, and round, sel_init, reg_wr_en and busy
// Parameters: NR (final round index), RW (round counter width, 2^RW > NR),
//             SETTLE (settling cycles between key_ack and reg_wr_en, 0 allowed)
// Optional feature: AES_CTRL_ABORT_EN adds bus.abort and bus.aborted. These
// let the environment cancel a block that is in flight.
module aes256_round_ctrl #(
    parameter int NR     = 14,
    parameter int RW     = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    aes256_round_ctrl_if.slave     bus
);
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        KEY_WAIT    = 3'd1,
        SETTLE_WAIT = 3'd2,
        WRITE       = 3'd3,
        DONE        = 3'd4
    } state_e;

    localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // The counter is loaded with SETTLE-1 and leaves at zero, so exactly
    // SETTLE cycles are spent in SETTLE_WAIT.
    localparam logic [CW-1:0] CNT_LOAD = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [RW-1:0] LAST     = RW'(NR);

    state_e        state_q, state_d;
    logic [RW-1:0] round_q, round_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, key_req_q, wr_q, sel_init_q, busy_q, out_valid_q;
    logic          abort_w;
    logic          aborted_d, aborted_q;

`ifdef AES_CTRL_ABORT_EN
    assign abort_w     = bus.abort;
    assign bus.aborted = aborted_q;
`else
    assign abort_w     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                // A simultaneous abort wins over a block start.
                if (bus.in_valid && !abort_w) begin
                    state_d = KEY_WAIT;
                    round_d = '0;
                end
            end
            KEY_WAIT: begin
                if (bus.key_ack) begin
                    if (SETTLE > 0) begin
                        state_d = SETTLE_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            SETTLE_WAIT: begin
                if (cnt_q == '0) state_d = WRITE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            WRITE: begin
                if (round_q == LAST) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + 1'b1;
                    state_d = KEY_WAIT;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    round_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
            end
        endcase

        aborted_d = abort_w && (state_q != IDLE);
        if (aborted_d) begin
            state_d = IDLE;
            round_d = '0;
        end
    end

    // All outputs are decoded from the next state and registered, so they
    // change together with state_q and carry no input-to-output path.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            round_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            key_req_q   <= 1'b0;
            wr_q        <= 1'b0;
            sel_init_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == IDLE);
            key_req_q   <= (state_d == KEY_WAIT);
            wr_q        <= (state_d == WRITE);
            busy_q      <= (state_d == KEY_WAIT) || (state_d == SETTLE_WAIT) || (state_d == WRITE);
            sel_init_q  <= ((state_d == KEY_WAIT) || (state_d == SETTLE_WAIT) || (state_d == WRITE))
                           && (round_d == '0);
            out_valid_q <= (state_d == DONE);
            aborted_q   <= aborted_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.key_req   = key_req_q;
    assign bus.round     = round_q;
    assign bus.sel_init  = sel_init_q;
    // An abort that lands on a WRITE cycle must not corrupt the state register.
    assign bus.reg_wr_en = wr_q & ~abort_w;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_aes256_round_ctrl.sv
module tb_aes256_round_ctrl;
    localparam int NR  = 14;
    localparam int RW  = 4;
    localparam int S_A = 1;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    aes256_round_ctrl_if #(.RW(RW)) ifa ();
    aes256_round_ctrl_if #(.RW(RW)) ifb ();

    aes256_round_ctrl #(.NR(NR), .RW(RW), .SETTLE(S_A)) dut_a (.clk(clk), .resetn(resetn), .bus(ifa));
    aes256_round_ctrl #(.NR(NR), .RW(RW), .SETTLE(0))   dut_b (.clk(clk), .resetn(resetn), .bus(ifb));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Per-round key_ack delay (in KEY_WAIT cycles) for DUT A.
    int dly_a [NR+1];
    int waited = 0;
    // key_ack is high whenever no key is requested, so a stray ack is always
    // present in SETTLE_WAIT/WRITE and across round boundaries.
    always @(negedge clk) begin
        if (ifa.key_req === 1'b1) begin
            if (waited < dly_a[ifa.round]) begin
                ifa.key_ack = 1'b0;
                waited++;
            end else begin
                ifa.key_ack = 1'b1;
            end
        end else begin
            waited      = 0;
            ifa.key_ack = 1'b1;
        end
    end

    // Monitors sample shortly after the falling edge, once the bench's own
    // negedge stimulus has settled.
    int wr_round[$];
    int wr_cyc[$];
    int wr_sel[$];
    int kreq_cnt  = 0;
    int rnd_viol  = 0;
    int excl_viol = 0;
    int wr_b      = 0;
    always @(negedge clk) begin
        #2;
        if (ifa.reg_wr_en === 1'b1) begin
            wr_round.push_back(int'(ifa.round));
            wr_cyc.push_back(cyc);
            wr_sel.push_back(int'(ifa.sel_init));
        end
        if (ifa.key_req === 1'b1) kreq_cnt++;
        if (ifa.round > NR || ifb.round > NR) rnd_viol++;
        if ((ifa.in_ready === 1'b1 && ifa.out_valid === 1'b1) ||
            (ifb.in_ready === 1'b1 && ifb.out_valid === 1'b1)) excl_viol++;
        if (ifb.reg_wr_en === 1'b1) wr_b++;
    end

    // One block on DUT A. Expected write instants come from the round rules:
    // round r spends 1+delay cycles in KEY_WAIT, S_A in SETTLE_WAIT, 1 in WRITE.
    task automatic run_block(input string nm, input int exp_lat, input int hold, input bit stray);
        int e0, lat, off, exp_c, sumd;
        bit got;
        wr_round.delete(); wr_cyc.delete(); wr_sel.delete();
        kreq_cnt = 0;
        @(negedge clk); ifa.in_valid = 1'b1;
        @(negedge clk); e0 = cyc; ifa.in_valid = 1'b0;
        chk({nm, ".accept_busy"}, ifa.busy, 1);
        got = 1'b0; lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ifa.out_valid === 1'b1) begin got = 1'b1; lat = cyc - e0; break; end
            if (stray) ifa.in_valid = 1'($urandom_range(0, 1));
        end
        ifa.in_valid = 1'b0;
        chk({nm, ".out_valid_seen"}, got, 1);
        chk({nm, ".latency"}, lat, exp_lat);
        for (int i = 0; i < hold; i++) begin
            chk({nm, ".hold_valid"}, ifa.out_valid, 1);
            chk({nm, ".hold_in_ready"}, ifa.in_ready, 0);
            @(negedge clk);
        end
        chk({nm, ".valid_before_ready"}, ifa.out_valid, 1);
        ifa.out_ready = 1'b1;
        @(negedge clk);
        ifa.out_ready = 1'b0;
        chk({nm, ".idle_in_ready"}, ifa.in_ready, 1);
        chk({nm, ".idle_round"}, ifa.round, 0);
        chk({nm, ".idle_out_valid"}, ifa.out_valid, 0);
        #3;
        chk({nm, ".n_writes"}, wr_round.size(), NR + 1);
        off = 0; sumd = 0;
        for (int r = 0; r <= NR; r++) begin
            exp_c = e0 + off + 1 + dly_a[r] + S_A;
            if (r < wr_round.size()) begin
                chk($sformatf("%s.wr%0d_round", nm, r), wr_round[r], r);
                chk($sformatf("%s.wr%0d_cycle", nm, r), wr_cyc[r], exp_c);
                chk($sformatf("%s.wr%0d_sel", nm, r), wr_sel[r], (r == 0) ? 1 : 0);
            end
            off  += 2 + S_A + dly_a[r];
            sumd += dly_a[r];
        end
        chk({nm, ".model_latency"}, lat, off);
        chk({nm, ".key_req_cycles"}, kreq_cnt, NR + 1 + sumd);
    endtask

    typedef struct {
        int dr;       // round whose key_ack is delayed
        int d;        // delay in cycles
        int hold;     // cycles out_ready is held low once out_valid rises
        bit stray;    // toggle in_valid while busy
        int exp_lat;  // accept edge to out_valid
    } vec_t;

    initial begin : main
        vec_t vt [5];
        int e0, lat, tmo, sum;
        bit got;

        vt[0] = '{0,  0, 0, 1'b0, 45};
        vt[1] = '{5,  3, 0, 1'b0, 48};
        vt[2] = '{14, 2, 2, 1'b1, 47};
        vt[3] = '{0,  5, 1, 1'b1, 50};
        vt[4] = '{7,  1, 4, 1'b1, 46};

        foreach (dly_a[r]) dly_a[r] = 0;
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.out_ready = 1'b0; ifb.key_ack = 1'b1;
`ifdef AES_CTRL_ABORT_EN
        ifa.abort = 1'b0; ifb.abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst.in_ready", ifa.in_ready, 1);
        chk("rst.round", ifa.round, 0);
        chk("rst.busy", ifa.busy, 0);
        chk("rst.key_req", ifa.key_req, 0);
        chk("rst.reg_wr_en", ifa.reg_wr_en, 0);
        chk("rst.out_valid", ifa.out_valid, 0);
        chk("rst.sel_init", ifa.sel_init, 0);
        resetn = 1'b1;

        for (int v = 0; v < 5; v++) begin
            foreach (dly_a[r]) dly_a[r] = 0;
            dly_a[vt[v].dr] = vt[v].d;
            run_block($sformatf("vec%0d", v), vt[v].exp_lat, vt[v].hold, vt[v].stray);
        end

        for (int k = 0; k < 4; k++) begin
            sum = 0;
            foreach (dly_a[r]) begin
                dly_a[r] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
                sum += dly_a[r];
            end
            run_block($sformatf("rnd%0d", k), (NR + 1) * (2 + S_A) + sum,
                      int'($urandom_range(0, 3)), 1'b1);
        end

        // Reset in SETTLE_WAIT of round 9.
        foreach (dly_a[r]) dly_a[r] = 0;
        @(negedge clk); ifa.in_valid = 1'b1;
        @(negedge clk); ifa.in_valid = 1'b0;
        got = 1'b0;
        for (tmo = 0; tmo < 100; tmo++) begin
            if (ifa.round == 9 && ifa.busy && !ifa.key_req && !ifa.reg_wr_en) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("rst9.reached", got, 1);
        resetn = 1'b0;
        #1;
        chk("rst9.in_ready", ifa.in_ready, 1);
        chk("rst9.round", ifa.round, 0);
        chk("rst9.busy", ifa.busy, 0);
        chk("rst9.reg_wr_en", ifa.reg_wr_en, 0);
        chk("rst9.key_req", ifa.key_req, 0);
        chk("rst9.out_valid", ifa.out_valid, 0);
        @(negedge clk); resetn = 1'b1;
        #3;
        wr_round.delete();
        repeat (20) @(negedge clk);
        #3;
        chk("rst9.no_writes", wr_round.size(), 0);
        chk("rst9.idle", ifa.in_ready, 1);

        // SETTLE=0: back-to-back blocks with out_ready held low 4 cycles.
        wr_b = 0;
        @(negedge clk); ifb.in_valid = 1'b1;
        @(negedge clk); e0 = cyc; ifb.in_valid = 1'b0;
        chk("b1.accept_busy", ifb.busy, 1);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ifb.out_valid === 1'b1) begin lat = cyc - e0; break; end
        end
        chk("b1.latency", lat, 30);
        for (int i = 0; i < 4; i++) begin
            chk("b1.hold_valid", ifb.out_valid, 1);
            chk("b1.hold_in_ready", ifb.in_ready, 0);
            if (i == 3) begin ifb.out_ready = 1'b1; ifb.in_valid = 1'b1; end
            @(negedge clk);
        end
        ifb.out_ready = 1'b0;
        chk("b1.release_in_ready", ifb.in_ready, 1);
        chk("b1.release_out_valid", ifb.out_valid, 0);
        chk("b1.release_round", ifb.round, 0);
        @(negedge clk); e0 = cyc; ifb.in_valid = 1'b0;
        chk("b2.accept_busy", ifb.busy, 1);
        chk("b2.accept_in_ready", ifb.in_ready, 0);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ifb.out_valid === 1'b1) begin lat = cyc - e0; break; end
        end
        chk("b2.latency", lat, 30);
        ifb.out_ready = 1'b1;
        @(negedge clk); ifb.out_ready = 1'b0;
        #3;
        chk("b.writes", wr_b, 2 * (NR + 1));

`ifdef AES_CTRL_ABORT_EN
        // Abort on the WRITE cycle of the last round.
        foreach (dly_a[r]) dly_a[r] = 0;
        wr_round.delete();
        @(negedge clk); ifa.in_valid = 1'b1;
        @(negedge clk); ifa.in_valid = 1'b0;
        got = 1'b0;
        for (tmo = 0; tmo < 100; tmo++) begin
            if (ifa.round == NR && ifa.key_req) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("abt.reached", got, 1);
        @(negedge clk);            // SETTLE_WAIT
        @(negedge clk);            // WRITE
        ifa.abort = 1'b1;
        #1;
        chk("abt.wr_gated", ifa.reg_wr_en, 0);
        chk("abt.round14", ifa.round, NR);
        @(negedge clk); ifa.abort = 1'b0;
        chk("abt.aborted", ifa.aborted, 1);
        chk("abt.in_ready", ifa.in_ready, 1);
        chk("abt.round0", ifa.round, 0);
        chk("abt.busy", ifa.busy, 0);
        @(negedge clk);
        chk("abt.aborted_once", ifa.aborted, 0);
        #3;
        chk("abt.n_writes", wr_round.size(), NR);
        ifa.abort = 1'b1; ifa.in_valid = 1'b1;
        @(negedge clk);
        ifa.abort = 1'b0; ifa.in_valid = 1'b0;
        chk("abt_idle.busy", ifa.busy, 0);
        chk("abt_idle.aborted", ifa.aborted, 0);
        chk("abt_idle.in_ready", ifa.in_ready, 1);
`endif

        chk("round_never_above_nr", rnd_viol, 0);
        chk("in_ready_out_valid_exclusive", excl_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/aes256_round_ctrl.md
Name: aes256_round_ctrl

Overview:
Round sequencer for the AES-256 encryption datapath. It accepts a block-start handshake and steps the round counter 0..14. Each round it requests the matching round key from key expansion, waits for the datapath to settle, then pulses the write enable of the 16-byte state register. The round counter also drives that register's input select: round 14 takes the final-round path without MixColumns. When all rounds are written, the block presents the result through a valid/ready handshake.

Parameters:
NR, 14, number of rounds; final round index; round counter stops at NR
RW, 4, width of the round counter; must satisfy 2^RW > NR
SETTLE, 1, idle cycles between key_ack and reg_wr_en for datapath settling; 0 allowed

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
in_valid  input  1  plaintext and key present and stable on the datapath
in_ready  output  1  controller can accept a block
key_req  output  1  request for round key index = round
key_ack  input  1  round key for the current round is available on the datapath
round  output  RW  current round index; drives the state register's round select and the key index
sel_init  output  1  high during round 0: state register loads plaintext XOR key0
reg_wr_en  output  1  one-cycle write strobe to the 16-byte state register
busy  output  1  high in any state other than IDLE or DONE
out_valid  output  1  state register holds ciphertext
out_ready  input  1  consumer accepts the ciphertext

Behaviour:
- Reset is asynchronous. On reset: state IDLE, round=0, in_ready=1, all other outputs 0. The SETTLE counter is cleared.
- All outputs are Moore, decoded from registered state, except where the optional feature states otherwise.
- States: IDLE, KEY_WAIT, SETTLE_WAIT, WRITE, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 → KEY_WAIT, round stays 0.
- KEY_WAIT:
  - key_req=1.
  - key_ack=1 → SETTLE_WAIT if SETTLE>0, else WRITE.
  - key_req stays high until ack; no timeout.
- SETTLE_WAIT:
  - Counts SETTLE cycles, then → WRITE.
  - Counter reloads on every entry.
- WRITE:
  - reg_wr_en=1 for exactly one cycle.
  - sel_init=(round==0).
  - round<NR → round<=round+1, then KEY_WAIT.
  - round==NR → DONE, round held at NR.
- DONE:
  - out_valid=1, held until out_ready=1.
  - Then → IDLE with round<=0.
  - out_valid may not drop without out_ready.
- Latency: with key_ack tied high, out_valid rises exactly (NR+1)*(2+SETTLE) clock edges after the accepting edge. That is 45 at the defaults, 30 with SETTLE=0.
- round never exceeds NR and never wraps. Round NR is the only write made with round==NR.
- Exactly NR+1 reg_wr_en pulses occur per block.
- Ignored inputs:
  - in_valid outside IDLE.
  - key_ack outside KEY_WAIT; an ack held high from the previous round does not count until the next KEY_WAIT cycle.
  - out_ready outside DONE.
- Reset asserted mid-block: immediate return to IDLE, round=0, no further reg_wr_en. The datapath contents are don't-care.
- in_ready and out_valid are never high together.

Optional Feature:
AES_CTRL_ABORT_EN
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit).
  - abort=1 in any non-IDLE state → IDLE on the next edge, with round=0.
  - reg_wr_en is gated combinationally by ~abort, so a WRITE coinciding with abort does not write.
  - aborted pulses for one cycle after the abort takes effect.
  - abort in IDLE is ignored and has priority over in_valid.
- Undefined: neither port exists, and the only way to terminate a block is reset.

Test Plan:
- Defaults, key_ack tied 1, in_valid pulse at edge E0:
  - 15 reg_wr_en pulses with round = 0,1,…,14.
  - sel_init high only with the first pulse.
  - out_valid rises at E0+45.
  - out_ready=1 → in_ready=1 and round=0 on the next cycle.
- key_ack delayed 3 cycles in round 5:
  - key_req stays high those cycles.
  - No reg_wr_en until 1+SETTLE cycles after the ack.
  - round stays 5 throughout.
- SETTLE=0, back-to-back blocks, out_ready held 0 for 4 cycles:
  - out_valid stays high 4 cycles.
  - in_ready stays low.
  - Second block's out_valid arrives 30 edges after its accept.
- resetn pulsed low while round=9 in SETTLE_WAIT:
  - All outputs go to reset values immediately.
  - No reg_wr_en after release until a new in_valid.
- Stray inputs: in_valid toggled while busy, and key_ack high while in SETTLE_WAIT → no effect on round or on the reg_wr_en count of 15.
- With AES_CTRL_ABORT_EN, abort asserted in the WRITE state of round 14:
  - reg_wr_en stays 0 that cycle.
  - aborted pulses once.
  - IDLE with round=0 next.
